pipe_stage_buf: RTL

Parametrised pipeline-stage buffer carrying an FP flag plus `CHANNELS` data words of `WIDTH` bits between two processor stages, e.g. ID->EX operand/message transport.
- Successor to the fixed 4-word stage buffer.
- Adds a clocked valid/ready handshake, stall holding, synchronous flush and a stall-length counter.
- An optional second skid entry makes `in_ready` purely registered.

---
 rtl/pipe_stage_buf_if.sv | 11 +
 rtl/pipe_stage_buf.sv | 98 +++++++++
 2 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready transport bundle between two pipeline stages.
interface pipe_stage_buf_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  logic                      in_valid, in_ready, in_fp;
  logic                      out_valid, out_ready, out_fp;
  logic [CHANNELS*WIDTH-1:0] in_data, out_data;
  modport slave  (input in_valid, in_fp, in_data, out_ready, output in_ready, out_valid, out_fp, out_data);
  modport master (output in_valid, in_fp, in_data, out_ready, input in_ready, out_valid, out_fp, out_data);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready stage buffer with stall hold, flush and saturating stall counter.
// Define PIPE_STAGE_BUF_SKID_EN for a second skid entry and a purely registered in_ready.
module pipe_stage_buf #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t                    state_q;
  logic                      vld_q, fp_q;
  logic [CHANNELS*WIDTH-1:0] data_q;
  logic [1:0]                occ_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      in_xfer, out_xfer;
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = vld_q && bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_fp    = fp_q;
  assign bus.out_data  = data_q;
  assign occupancy     = occ_q;
  assign stall_cnt     = cnt_q;
`ifdef PIPE_STAGE_BUF_SKID_EN
  logic                      rdy_q, skid_fp_q;
  logic [CHANNELS*WIDTH-1:0] skid_data_q;
  // in_ready is forced low only while reset is held
  assign bus.in_ready = rst_n && rdy_q;
`else
  assign bus.in_ready = rst_n && (!vld_q || bus.out_ready);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      vld_q   <= 1'b0;
      fp_q    <= 1'b0;
      data_q  <= '0;
      occ_q   <= 2'd0;
      cnt_q   <= '0;
`ifdef PIPE_STAGE_BUF_SKID_EN
      rdy_q       <= 1'b1;
      skid_fp_q   <= 1'b0;
      skid_data_q <= '0;
`endif
    end else begin
      cnt_q <= (vld_q && !bus.out_ready && !flush) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
      if (flush) begin
        state_q <= EMPTY;
        vld_q   <= 1'b0;
        occ_q   <= 2'd0;
`ifdef PIPE_STAGE_BUF_SKID_EN
        rdy_q   <= 1'b1;
`endif
      end else begin
        case (state_q)
          EMPTY: if (in_xfer) begin
            fp_q    <= bus.in_fp;
            data_q  <= bus.in_data;
            vld_q   <= 1'b1;
            occ_q   <= 2'd1;
            state_q <= ONE;
          end
          ONE: if (in_xfer && out_xfer) begin
            fp_q   <= bus.in_fp;
            data_q <= bus.in_data;
          end else if (out_xfer) begin
            vld_q   <= 1'b0;
            occ_q   <= 2'd0;
            state_q <= EMPTY;
`ifdef PIPE_STAGE_BUF_SKID_EN
          end else if (in_xfer) begin
            skid_fp_q   <= bus.in_fp;
            skid_data_q <= bus.in_data;
            rdy_q       <= 1'b0;
            occ_q       <= 2'd2;
            state_q     <= TWO;
`endif
          end
`ifdef PIPE_STAGE_BUF_SKID_EN
          TWO: if (out_xfer) begin
            fp_q    <= skid_fp_q;
            data_q  <= skid_data_q;
            rdy_q   <= 1'b1;
            occ_q   <= 2'd1;
            state_q <= ONE;
          end
`endif
          default: state_q <= EMPTY;
        endcase
      end
    end
  end
endmodule
